// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard control for load-use stalls, slow data memory waits and taken-branch flushes.
// RUN/MEM_WAIT outputs are combinational; a sticky ERR state traps memory timeouts.
module hazard_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [6:0]  IFID_opcode_i,
    input  logic [4:0]  IFID_RS1addr_i,
    input  logic [4:0]  IFID_RS2addr_i,
    input  logic        IDEX_MemRead_i,
    input  logic [4:0]  IDEX_RDaddr_i,
    input  logic        Branch_taken_i,
    input  logic        mem_req_i,
    input  logic        mem_ack_i,
    output logic        Noop_o,
    output logic        PCWrite_o,
    output logic        IFIDWrite_o,
    output logic        IFIDFlush_o,
    output logic        PipeStall_o,
    output logic        err_o,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o
);
    typedef enum logic [1:0] {HALT, RUN, MEM_WAIT, ERR} state_t;
    state_t     state;
    logic [7:0] wait_cnt;
    logic       use_rs1, use_rs2, lu, mm, active;
    always_comb begin
        use_rs2     = IFID_opcode_i == 7'b0110011 || IFID_opcode_i == 7'b0100011 || IFID_opcode_i == 7'b1100011;
        use_rs1     = use_rs2 || IFID_opcode_i == 7'b0010011 || IFID_opcode_i == 7'b0000011;
        lu          = IDEX_MemRead_i && IDEX_RDaddr_i != 5'd0 &&
                      ((use_rs1 && IDEX_RDaddr_i == IFID_RS1addr_i) || (use_rs2 && IDEX_RDaddr_i == IFID_RS2addr_i));
        mm          = mem_req_i && !mem_ack_i;
        // The ack cycle of a memory wait behaves like a normal RUN cycle without a miss
        active      = (state == RUN && !mm) || (state == MEM_WAIT && mem_ack_i);
        Noop_o      = state == HALT || state == ERR || (active && lu);
        PCWrite_o   = active && !lu;
        IFIDWrite_o = active && !lu;
        IFIDFlush_o = active && !lu && Branch_taken_i;
        PipeStall_o = (state == RUN && mm) || (state == MEM_WAIT && !mem_ack_i) || state == ERR;
        err_o       = state == ERR;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= HALT;
            wait_cnt    <= 8'd0;
            stall_cnt_o <= 16'd0;
            flush_cnt_o <= 16'd0;
        end else begin
            case (state)
                HALT: state <= RUN;
                RUN: if (mm) begin
                    state    <= MEM_WAIT;
                    wait_cnt <= 8'd0;
                end
                MEM_WAIT: if (mem_ack_i) state <= RUN;
                else if (wait_cnt == 8'(TIMEOUT - 1)) state <= ERR;
                else wait_cnt <= wait_cnt + 8'd1;
                ERR: state <= ERR;
            endcase
            if (!PCWrite_o && state != HALT && stall_cnt_o != 16'hFFFF) stall_cnt_o <= stall_cnt_o + 16'd1;
            if (IFIDFlush_o && flush_cnt_o != 16'hFFFF) flush_cnt_o <= flush_cnt_o + 16'd1;
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: scoreboard bench; expected controls/counters queued per driven cycle, compared at negedge.
module tb_hazard_unit;
    localparam int TIMEOUT = 255;
    // ctl bits: {Noop, PCWrite, IFIDWrite, IFIDFlush, PipeStall, err}
    localparam logic [5:0] NORM = 6'b011000, LUS = 6'b100000, BR = 6'b011100,
                           MMS = 6'b000010, ERRS = 6'b100011, RSTS = 6'b100000;
    logic clk_i = 0, rst_i = 0;
    logic [6:0] IFID_opcode_i = 0;
    logic [4:0] IFID_RS1addr_i = 0, IFID_RS2addr_i = 0, IDEX_RDaddr_i = 0;
    logic IDEX_MemRead_i = 0, Branch_taken_i = 0, mem_req_i = 0, mem_ack_i = 0;
    logic Noop_o, PCWrite_o, IFIDWrite_o, IFIDFlush_o, PipeStall_o, err_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;
    typedef struct {
        string       tag;
        logic [5:0]  ctl;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;
    exp_t q[$];
    exp_t e;
    int n_cmp = 0, n_bad = 0;
    logic [15:0] esc = 0, efc = 0;
    hazard_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .IFID_opcode_i(IFID_opcode_i),
        .IFID_RS1addr_i(IFID_RS1addr_i), .IFID_RS2addr_i(IFID_RS2addr_i),
        .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_RDaddr_i(IDEX_RDaddr_i),
        .Branch_taken_i(Branch_taken_i), .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
        .Noop_o(Noop_o), .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o),
        .IFIDFlush_o(IFIDFlush_o), .PipeStall_o(PipeStall_o), .err_o(err_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );
    always #5 clk_i = ~clk_i;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [5:0] ctl_now();
        return {Noop_o, PCWrite_o, IFIDWrite_o, IFIDFlush_o, PipeStall_o, err_o};
    endfunction
    always @(negedge clk_i) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            check({e.tag, ".ctl"}, 32'(ctl_now()), 32'(e.ctl));
            check({e.tag, ".stall_cnt"}, 32'(stall_cnt_o), 32'(e.sc));
            check({e.tag, ".flush_cnt"}, 32'(flush_cnt_o), 32'(e.fc));
        end
    end
    task automatic drive(input string tag, input logic [6:0] opc, input logic [4:0] r1, input logic [4:0] r2,
                         input logic mr, input logic [4:0] rd, input logic br, input logic req,
                         input logic ack, input logic [5:0] ctl);
        IFID_opcode_i = opc; IFID_RS1addr_i = r1; IFID_RS2addr_i = r2;
        IDEX_MemRead_i = mr; IDEX_RDaddr_i = rd; Branch_taken_i = br;
        mem_req_i = req; mem_ack_i = ack;
        q.push_back('{tag, ctl, esc, efc});
        if (!ctl[4]) esc++;
        if (ctl[2]) efc++;
        @(posedge clk_i);
        #1;
    endtask
    task automatic idle(input string tag);
        drive(tag, 7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NORM);
    endtask
    // Asserts reset between edges and checks it acts immediately, then walks HALT -> RUN
    task automatic reset_check(input string tag);
        rst_i = 1;
        #1;
        check({tag, ".rst_ctl"}, 32'(ctl_now()), 32'(RSTS));
        check({tag, ".rst_sc"}, 32'(stall_cnt_o), 32'd0);
        check({tag, ".rst_fc"}, 32'(flush_cnt_o), 32'd0);
        {IFID_opcode_i, IFID_RS1addr_i, IFID_RS2addr_i, IDEX_RDaddr_i} = '0;
        {IDEX_MemRead_i, Branch_taken_i, mem_req_i, mem_ack_i} = '0;
        esc = 0; efc = 0;
        @(posedge clk_i);
        #1 rst_i = 0;
        #1 check({tag, ".halt_ctl"}, 32'(ctl_now()), 32'(RSTS));
        @(posedge clk_i);
        #1;
    endtask
    initial begin
        #2 reset_check("por");
        idle("idle0");
        drive("lu_rs2", 7'b0110011, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, LUS);
        idle("after_lu");
        drive("rd0", 7'b0110011, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, NORM);
        drive("imm_rs2", 7'b0010011, 5'd3, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, NORM);
        drive("load_rs1", 7'b0000011, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, LUS);
        drive("store_rs2", 7'b0100011, 5'd2, 5'd12, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0, LUS);
        drive("br_rs1", 7'b1100011, 5'd31, 5'd4, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, LUS);
        drive("no_memread", 7'b0110011, 5'd6, 5'd6, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0, NORM);
        drive("jal_match", 7'b1101111, 5'd8, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, NORM);
        drive("br_with_lu", 7'b0110011, 5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, LUS);
        drive("br_alone", 7'b0110011, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, BR);
        idle("after_br");
        for (int i = 0; i < 3; i++) drive($sformatf("mw%0d", i), 7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, MMS);
        drive("mw_ack", 7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NORM);
        idle("after_mw");
        drive("zero_wait", 7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NORM);
        idle("after_zw");
        drive("mm_over_lu", 7'b0110011, 5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, MMS);
        drive("ack_br", 7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, BR);
        drive("mm2", 7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, MMS);
        drive("ack_lu", 7'b0000011, 5'd3, 5'd0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1, LUS);
        drive("mw_rst0", 7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, MMS);
        drive("mw_rst1", 7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, MMS);
        reset_check("mid_wait");
        idle("post_rst");
        for (int i = 0; i < TIMEOUT + 1; i++)
            drive($sformatf("to%0d", i), 7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, MMS);
        drive("err_ack", 7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, ERRS);
        drive("err_idle", 7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ERRS);
        drive("err_lu", 7'b0110011, 5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, ERRS);
        #2 reset_check("in_err");
        idle("recovered");
        check("drain", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
